// File: rtl/tc_timer_pkg.sv
// Shared definitions for the tc_timer countdown timer: FSM states,
// register offsets, mode codes and the CTRL field layout.
package tc_timer_pkg;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam logic [1:0] TC_MODE_ONCE   = 2'b00;
  localparam logic [1:0] TC_MODE_PERIOD = 2'b01;

  // Bit 3 = IM, bits 2:1 = Mode, bit 0 = En.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tc_ctrl_t;

  // Mode codes 10 and 11 fall back to one-shot behaviour.
  function automatic logic is_periodic(input tc_ctrl_t c);
    return c.mode == TC_MODE_PERIOD;
  endfunction

endpackage

// File: rtl/tc_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT register window,
// one-shot or auto-reload periodic countdown, masked interrupt request.
module tc_timer
  import tc_timer_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  tc_state_e   state_q, state_d;
  tc_ctrl_t    ctrl_q, ctrl_d;
  logic [31:0] preset_q;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= TC_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      if (We && Addr == TC_PRESET)
        preset_q <= Din;
    end
  end

  // FSM decisions read only the pre-edge registers; a CTRL bus write is
  // applied last so it overrides any FSM update of CTRL or irq_flag.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      TC_IDLE: begin
        if (ctrl_q.en)
          state_d = TC_LOAD;
      end
      TC_LOAD: begin
        count_d = preset_q;
        state_d = TC_CNT;
      end
      TC_CNT: begin
        if (!ctrl_q.en) begin
          state_d = TC_IDLE;
        end else if (count_q == '0) begin
          state_d    = TC_INT;
          irq_flag_d = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      TC_INT: begin
        if (is_periodic(ctrl_q)) begin
          irq_flag_d = 1'b0;
          state_d    = TC_LOAD;
        end else begin
          ctrl_d.en = 1'b0;
          state_d   = TC_IDLE;
        end
      end
      default: state_d = TC_IDLE;
    endcase

    if (We && Addr == TC_CTRL) begin
      ctrl_d     = tc_ctrl_t'(Din[3:0]);
      irq_flag_d = 1'b0;
    end
  end

  always_comb begin
    case (Addr)
      TC_CTRL:   Dout = {28'd0, ctrl_q};
      TC_PRESET: Dout = preset_q;
      TC_COUNT:  Dout = count_q;
      default:   Dout = '0;
    endcase
  end

  assign IRQ = ctrl_q.im & irq_flag_q;

endmodule

// File: tb/tb_tc_timer.sv
// Directed self-checking bench for tc_timer.
module tb_tc_timer;
  import tc_timer_pkg::*;

  logic        Clk;
  logic        Rst;
  logic [1:0]  Addr;
  logic        We;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int unsigned total = 0;
  int unsigned bad   = 0;

  tc_timer dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .Addr (Addr),
    .We   (We),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(tag, Dout, exp);
  endtask

  // Call between edges; the write lands on the next rising edge and the
  // task returns at the following falling edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    We   = 1'b1;
    @(negedge Clk);
    We   = 1'b0;
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    Rst  = 1'b1;
    We   = 1'b0;
    Addr = 2'd0;
    Din  = '0;
    step(2);
    Rst = 1'b0;

    // Reset state
    rd_chk("rst_ctrl",   2'd0, 32'd0);
    rd_chk("rst_preset", 2'd1, 32'd0);
    rd_chk("rst_count",  2'd2, 32'd0);
    rd_chk("rst_rsvd",   2'd3, 32'd0);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    chk("rst_state", {30'd0, dut.state_q}, {30'd0, TC_IDLE});

    // One-shot, PRESET = 5, IM = 1
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);                          // e0
    step(1);                                  // after e1: LOAD
    rd_chk("os_e1_count", 2'd2, 32'd0);
    step(1);                                  // after e2
    rd_chk("os_e2_count", 2'd2, 32'd5);
    for (int k = 1; k <= 5; k++) begin
      step(1);
      rd_chk("os_countdown", 2'd2, 32'(5 - k));
      chk("os_irq_low", {31'd0, IRQ}, 32'd0);
    end
    step(1);                                  // after e8
    chk("os_irq_rise", {31'd0, IRQ}, 32'd1);
    step(1);
    rd_chk("os_ctrl_after", 2'd0, 32'h8);
    step(3);
    chk("os_irq_hold", {31'd0, IRQ}, 32'd1);
    wr(2'd0, 32'h0);
    chk("os_irq_clear", {31'd0, IRQ}, 32'd0);

    // Masked one-shot
    wr(2'd0, 32'h1);
    step(8);                                  // after e8: INT with IM = 0
    chk("mask_irq_int", {31'd0, IRQ}, 32'd0);
    step(1);
    rd_chk("mask_ctrl", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    chk("mask_irq_after_im", {31'd0, IRQ}, 32'd0);
    rd_chk("mask_ctrl_im", 2'd0, 32'h8);
    wr(2'd0, 32'h0);

    // Periodic, PRESET = 3: IRQ after e6, e12, e18, e24
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int i = 1; i <= 26; i++) begin
      step(1);
      chk("per_irq", {31'd0, IRQ}, (i >= 6 && (i - 6) % 6 == 0) ? 32'd1 : 32'd0);
    end
    wr(2'd0, 32'h0);
    step(3);

    // Disable mid-count, PRESET = 10
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    step(6);                                  // after e6
    rd_chk("dis_count6", 2'd2, 32'd6);
    wr(2'd0, 32'h8);                          // lands e7, decrements once more
    rd_chk("dis_count5", 2'd2, 32'd5);
    step(4);
    rd_chk("dis_frozen", 2'd2, 32'd5);
    chk("dis_state", {30'd0, dut.state_q}, {30'd0, TC_IDLE});
    chk("dis_irq", {31'd0, IRQ}, 32'd0);
    wr(2'd0, 32'h9);
    step(1);
    rd_chk("reen_e1", 2'd2, 32'd5);
    step(1);
    rd_chk("reen_reload", 2'd2, 32'd10);
    wr(2'd0, 32'h0);                          // count 9, then IDLE
    step(1);
    rd_chk("stop_count", 2'd2, 32'd9);

    // Ignored writes
    wr(2'd2, 32'h55);
    rd_chk("wr_count_ignored", 2'd2, 32'd9);
    wr(2'd3, 32'hFFFF_FFFF);
    rd_chk("wr_rsvd_zero", 2'd3, 32'd0);
    rd_chk("wr_rsvd_ctrl", 2'd0, 32'h0);
    rd_chk("wr_rsvd_preset", 2'd1, 32'd10);

    // CTRL write on the one-shot INT edge, PRESET = 2
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);                          // e0
    step(5);                                  // after e5: INT
    chk("col_irq_int", {31'd0, IRQ}, 32'd1);
    wr(2'd0, 32'hD);                          // lands e6 with FSM clearing En
    rd_chk("col_ctrl", 2'd0, 32'hD);
    chk("col_irq", {31'd0, IRQ}, 32'd0);
    step(2);                                  // restart: LOAD, then count = 2
    rd_chk("col_reload", 2'd2, 32'd2);
    wr(2'd1, 32'd100);                        // PRESET write during CNT
    rd_chk("pre_mid_count", 2'd2, 32'd1);
    rd_chk("pre_mid_preset", 2'd1, 32'd100);
    step(1);
    rd_chk("pre_mid_zero", 2'd2, 32'd0);
    wr(2'd0, 32'h0);
    step(3);

    // Asynchronous reset mid-count, PRESET = 20
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h9);
    step(15);                                 // after e15: count = 7
    rd_chk("arst_pre_count", 2'd2, 32'd7);
    Rst = 1'b1;
    #1;
    chk("arst_count", Dout, 32'd0);
    chk("arst_irq", {31'd0, IRQ}, 32'd0);
    chk("arst_state", {30'd0, dut.state_q}, {30'd0, TC_IDLE});
    rd_chk("arst_ctrl", 2'd0, 32'd0);
    rd_chk("arst_preset", 2'd1, 32'd0);
    step(1);
    Rst = 1'b0;

    // Reset with IRQ high: drops without a clock edge
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);                          // PRESET = 0: INT at e3
    step(3);
    chk("arst2_irq_high", {31'd0, IRQ}, 32'd1);
    #1;
    Rst = 1'b1;
    #1;
    chk("arst2_irq_drop", {31'd0, IRQ}, 32'd0);
    step(1);
    Rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
